uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one uart_send transmitter among NREQ byte producers. It runs entirely in the clk_sample domain and latches the granted requester's byte onto din. It issues the active-low wrn strobe that uart_send edge-detects, then tracks send_over to know when the frame is done. Each requester gets a one-cycle ack; a watchdog recovers from a transmitter that never completes.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the uart_send request arbiter and its helpers.
package uart_tx_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int WRN_LOW_DEF = 2;
    localparam int GAP_CYC_DEF = 2;
    // 16 bits leaves room for 12 baud periods plus 40 cycles at common sample/baud ratios.
    localparam int TO_W_DEF    = 16;

    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_ARB       = 6'b000010,
        S_STROBE    = 6'b000100,
        S_WAIT_DONE = 6'b001000,
        S_WAIT_REL  = 6'b010000,
        S_GAP       = 6'b100000
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping around.
module uart_tx_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            valid
);

    always_comb begin
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx]) begin
                winner = ID_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_send transmitter among NREQ byte producers with round-robin grants,
// a low-active wrn strobe, completion tracking on send_over and a stuck-transmitter watchdog.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int WRN_LOW = WRN_LOW_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic                      clk_sample,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [8*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           ack,
    output logic                      wrn,
    output logic [7:0]                din,
    input  logic                      send_over,
    output logic                      busy,
    output logic [id_width(NREQ)-1:0] grant_id,
    output logic                      timeout_err,
    output logic [5:0]                state_dbg
);

    // Handshake: req[i] is a level held with req_data[i] until ack[i] pulses for one cycle;
    // the cycle after ack the requester drops req[i] or keeps it high to offer a new byte.

    localparam int ID_W    = id_width(NREQ);
    localparam int CNT_MAX = (WRN_LOW > GAP_CYC) ? WRN_LOW : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [TO_W-1:0]   wd;
    logic [TO_W-1:0]   wd_inc;
    logic [ID_W-1:0]   pick_id;
    logic              pick_valid;
    logic [NREQ-1:0]   ack_mask;

    uart_tx_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    assign wd_inc    = wd + 1'b1;
    assign ack_mask  = NREQ'(1) << grant_id;
    assign state_dbg = state;

    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ptr         <= ID_W'(NREQ - 1);
            cnt         <= '0;
            wd          <= '0;
            wrn         <= 1'b1;
            din         <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            ack         <= '0;
            timeout_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|req) begin
                        state <= S_ARB;
                        busy  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (pick_valid) begin
                        din      <= req_data[8*int'(pick_id) +: 8];
                        grant_id <= pick_id;
                        ptr      <= pick_id;
                        cnt      <= '0;
                        state    <= S_STROBE;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_STROBE: begin
                    // First cycle here drops wrn; it rises again after WRN_LOW low cycles.
                    if (cnt == CNT_W'(WRN_LOW)) begin
                        wrn   <= 1'b1;
                        cnt   <= '0;
                        wd    <= '0;
                        state <= S_WAIT_DONE;
                    end else begin
                        wrn <= 1'b0;
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (send_over) begin
                        ack   <= ack_mask;
                        wd    <= wd_inc;
                        state <= S_WAIT_REL;
                    end else if (wd_inc == '1) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= S_GAP;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                S_WAIT_REL: begin
                    if (!send_over) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end else if (wd_inc == '1) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= S_GAP;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    wrn   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int WRN_LOW = 2;
    localparam int GAP_CYC = 2;
    localparam int TO_W    = 4;
    localparam int WD_CYC  = (1 << TO_W) - 1;

    logic              clk_sample = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              wrn;
    logic [7:0]        din;
    logic              send_over;
    logic              busy;
    logic [1:0]        grant_id;
    logic              timeout_err;
    logic [5:0]        state_dbg;

    uart_tx_arbiter #(
        .NREQ (NREQ), .WRN_LOW (WRN_LOW), .GAP_CYC (GAP_CYC), .TO_W (TO_W)
    ) dut (
        .clk_sample  (clk_sample),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .wrn         (wrn),
        .din         (din),
        .send_over   (send_over),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk_sample = ~clk_sample;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    int grant_log[$];

    int cyc = 0, fall_m = 0, rise_m = 0, so_fall_m = -100, wlow = 0;
    int n_strobe = 0, n_ack = 0, n_to = 0, n_issue = 0;
    int model_ptr = NREQ - 1, cur = 0;
    logic [7:0] cur_din = '0;
    logic frame_open = 1'b0, in_strobe = 1'b0;
    logic wrn_d = 1'b1, so_d = 1'b0;
    logic [NREQ-1:0] req_d1 = '0;
    logic [8*NREQ-1:0] data_d1 = '0;

    logic stuck = 1'b0, rand_on = 1'b0;
    logic [NREQ-1:0] renew = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Round-robin rule: first pending requester strictly after the last grant, wrapping.
    function automatic int rr_model(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // ---------------- monitor / reference model ----------------
    always @(negedge clk_sample) begin : mon
        int w;
        cyc++;
        if (!rst) begin
            model_ptr  = NREQ - 1;
            frame_open = 1'b0;
            in_strobe  = 1'b0;
            so_fall_m  = -100;
        end else begin
            if (wrn_d && !wrn) begin
                w = rr_model(req_d1, model_ptr);
                chk("strobe_has_req", 32'(req_d1 != 0), 1);
                chk("overlap", 32'(frame_open), 0);
                if (w < 0) w = 0;
                chk("grant_id", 32'(grant_id), w);
                chk("din", 32'(din), 32'(data_d1[8*w +: 8]));
                if (exp_q.size() > 0) chk("din_seq", 32'(din), 32'(exp_q.pop_front()));
                model_ptr  = w;
                cur        = w;
                cur_din    = data_d1[8*w +: 8];
                frame_open = 1'b1;
                in_strobe  = 1'b1;
                wlow       = 0;
                fall_m     = cyc;
                grant_log.push_back(w);
                n_strobe++;
            end
            if (!wrn) wlow++;
            if (in_strobe && wrn) begin
                chk("wrn_low_len", wlow, WRN_LOW);
                in_strobe = 1'b0;
                rise_m    = cyc;
            end
            if (ack != 0) begin
                if (frame_open && !in_strobe) begin
                    chk("ack_onehot", 32'(ack), 32'(1) << cur);
                    chk("ack_send_over", 32'(send_over), 1);
                    chk("ack_din_stable", 32'(din), 32'(cur_din));
                    chk("ack_grant_id", 32'(grant_id), cur);
                    frame_open = 1'b0;
                    n_ack++;
                end else begin
                    chk("ack_unexpected", 32'(ack), 0);
                end
            end
            if (frame_open && !in_strobe && stuck && (cyc - rise_m == WD_CYC))
                chk("wd_pulse", 32'(timeout_err), 1);
            if (timeout_err) begin
                chk("to_expected", 32'({frame_open, stuck}), 3);
                chk("wd_latency", cyc - rise_m, WD_CYC);
                frame_open = 1'b0;
                n_to++;
            end
            if (so_d && !send_over && !frame_open) so_fall_m = cyc;
            if (cyc == so_fall_m + GAP_CYC - 1) chk("busy_gap", 32'(busy), 1);
            if (cyc == so_fall_m + GAP_CYC)     chk("busy_idle", 32'(busy), 0);
        end
        wrn_d   = wrn;
        so_d    = send_over;
        req_d1  = req;
        data_d1 = req_data;
    end

    // ---------------- transmitter model ----------------
    initial begin : tx_model
        int tx_t, tx_dly, tx_hold;
        send_over = 1'b0;
        tx_t = -1; tx_dly = 0; tx_hold = 2;
        forever begin
            @(negedge clk_sample); #1;
            if (!rst) begin
                send_over = 1'b0;
                tx_t = -1;
            end else if (tx_t < 0) begin
                if (!wrn) begin
                    tx_t    = 0;
                    tx_dly  = $urandom_range(0, 5);
                    tx_hold = $urandom_range(2, 4);
                end
            end else begin
                tx_t++;
            end
            if (rst && tx_t >= 0) begin
                if (stuck) begin
                    if (timeout_err) tx_t = -1;
                end else if (tx_t == WRN_LOW - 1 + tx_dly) begin
                    send_over = 1'b1;
                end else if (tx_t == WRN_LOW - 1 + tx_dly + tx_hold) begin
                    send_over = 1'b0;
                    tx_t = -1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk_sample); #2;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && ack[i]) begin
                if (renew[i] || (rand_on && $urandom_range(0, 1) == 1)) begin
                    n_issue++;
                    if (rand_on) req_data[8*i +: 8] = 8'($urandom);
                end else begin
                    req[i] = 1'b0;
                end
            end else if (!req[i] && rand_on && $urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                req_data[8*i +: 8] = 8'($urandom);
                n_issue++;
            end
        end
    endtask

    task automatic wait_strobe(input int s, input string tag);
        for (int i = 0; i < 300 && n_strobe <= s; i++) step();
        chk(tag, 32'(n_strobe > s), 1);
    endtask

    task automatic drain();
        rand_on = 1'b0;
        renew   = '0;
        for (int i = 0; i < 600 && (req != 0 || busy); i++) step();
        chk("drain_idle", 32'({req, busy}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_sample); #2;
        rst = 1'b0; req = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, a0, set_m, first;
        rst = 1'b0; req = '0; req_data = '0;
        repeat (3) @(negedge clk_sample);
        chk("rst_wrn", 32'(wrn), 1);
        chk("rst_din", 32'(din), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        #2 rst = 1'b1;
        repeat (3) step();

        // single requester and strobe latency
        exp_q.push_back(8'hA5);
        req[1] = 1'b1; req_data[15:8] = 8'hA5;
        set_m = cyc;
        s = n_strobe;
        wait_strobe(s, "t1_strobe");
        chk("t1_latency", fall_m - set_m, 3);
        drain();

        // simultaneous requests after reset: strict rotation
        do_reset();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        renew = '1;
        req = '1;
        s = n_strobe;
        for (int i = 0; i < 600 && n_strobe < s + 5; i++) step();
        chk("t2_five_grants", 32'(n_strobe >= s + 5), 1);
        chk("t2_seq_done", exp_q.size(), 0);
        drain();

        // fairness: req[0] permanent, req[2] once
        renew = 4'b0001;
        req[0] = 1'b1; req_data[7:0] = 8'h0F;
        s = n_strobe;
        wait_strobe(s, "t3_first");
        req[2] = 1'b1; req_data[23:16] = 8'h2E;
        s = n_strobe;
        wait_strobe(s, "t3_next");
        chk("t3_fair_grant", grant_log[s], 2);
        drain();

        // watchdog: stuck transmitter, next grant moves on
        stuck = 1'b1;
        a0 = n_ack;
        req_data[15:0] = 16'h3C5A;
        req[1:0] = 2'b11;
        s = n_strobe;
        first = n_to;
        for (int i = 0; i < 300 && n_to == first; i++) step();
        chk("t4_timeout_seen", n_to - first, 1);
        chk("t4_no_ack", n_ack - a0, 0);
        stuck = 1'b0;
        wait_strobe(s + 1, "t4_after");
        chk("t4_skip", grant_log[s + 1], (grant_log[s] == 0) ? 1 : 0);
        drain();

        // drop req mid-transfer: ack still comes, no second frame
        req[2] = 1'b1; req_data[23:16] = 8'hD2;
        s = n_strobe;
        a0 = n_ack;
        for (int i = 0; i < 300 && !(n_strobe > s && wrn && !in_strobe); i++) step();
        req[2] = 1'b0;
        for (int i = 0; i < 100 && n_ack == a0; i++) step();
        chk("t5_drop_ack", n_ack - a0, 1);
        repeat (20) step();
        chk("t5_no_refire", n_strobe - s, 1);

        // reset during strobe
        req[1] = 1'b1; req_data[15:8] = 8'h77;
        for (int i = 0; i < 300 && wrn; i++) step();
        chk("t6_in_strobe", 32'(wrn), 0);
        rst = 1'b0;
        #1;
        chk("t6_wrn", 32'(wrn), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ack", 32'(ack), 0);
        chk("t6_din", 32'(din), 0);
        req = '1;
        req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        repeat (2) step();
        rst = 1'b1;
        s = n_strobe;
        wait_strobe(s, "t6_regrant");
        chk("t6_first_grant", grant_log[s], 0);
        drain();

        // random traffic, every issued byte acked exactly once
        n_issue = 0;
        a0 = n_ack;
        rand_on = 1'b1;
        repeat (1500) step();
        drain();
        chk("t7_acks_vs_issued", n_ack - a0, n_issue);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
